alarm_time_counter: RTL and testbench

ALARM_TIME_COUNTER -- requirements
Module: alarm_time_counter

---
 rtl/alarm_time_counter_if.sv | 19 +
 rtl/alarm_time_counter.sv | 125 ++++++++++++
 tb/tb_alarm_time_counter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/alarm_time_counter_if.sv
// Avalon-MM slave bus bundle for alarm_time_counter: word address, select,
// active-low write strobe, 32-bit write data and zero-wait-state read data.
interface alarm_time_counter_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/alarm_time_counter.sv
// Modulo-N alarm/time counter with an Avalon-MM register file, carry pulse and wrap flag.
// Optional interrupt output enabled by defining ALARM_TIME_COUNTER_IRQ_EN.
module alarm_time_counter #(
  parameter int DATA_WIDTH    = 16,
  parameter int RESET_COUNT   = 0,
  parameter int RESET_MODULUS = 24
) (
  input  logic                   clk,
  input  logic                   reset_n,
  alarm_time_counter_if.slave    bus,
  input  logic                   tick,
  output logic [DATA_WIDTH-1:0]  out_port,
  output logic                   carry_out,
  output logic                   irq
);

  typedef logic [DATA_WIDTH-1:0] data_t;

  localparam logic [2:0] ADDR_COUNT   = 3'd0;
  localparam logic [2:0] ADDR_MODULUS = 3'd1;
  localparam logic [2:0] ADDR_CONTROL = 3'd2;
  localparam logic [2:0] ADDR_STATUS  = 3'd3;
  localparam logic [2:0] ADDR_STEP    = 3'd4;

  data_t count_q, count_d;
  data_t modulus_q, modulus_d;
  data_t top_value;
  logic  run_q, run_d;
  logic  irq_en_q, irq_en_d;
  logic  wrap_q, wrap_d;
  logic  carry_q, carry_d;
  logic  irq_q, irq_d;
  logic  wr_en, count_wr, inc;
  logic  unused_wd;

  assign unused_wd = ^bus.writedata;

  always_comb begin
    wr_en    = bus.chipselect & ~bus.write_n;
    count_wr = wr_en && (bus.address == ADDR_COUNT);
    inc      = (tick & run_q) | (wr_en && (bus.address == ADDR_STEP));
    // A modulus of zero selects the full binary range, wrapping at all-ones.
    top_value = (modulus_q == '0) ? '1 : modulus_q - data_t'(1);

    count_d = count_q;
    carry_d = 1'b0;
    if (count_wr) begin
      count_d = bus.writedata[DATA_WIDTH-1:0];
    end else if (inc) begin
      if (count_q >= top_value) begin
        count_d = '0;
        carry_d = 1'b1;
      end else begin
        count_d = count_q + data_t'(1);
      end
    end

    modulus_d = modulus_q;
    if (wr_en && (bus.address == ADDR_MODULUS)) begin
      modulus_d = bus.writedata[DATA_WIDTH-1:0];
    end

    run_d    = run_q;
    irq_en_d = irq_en_q;
    if (wr_en && (bus.address == ADDR_CONTROL)) begin
      run_d = bus.writedata[0];
`ifdef ALARM_TIME_COUNTER_IRQ_EN
      irq_en_d = bus.writedata[1];
`else
      irq_en_d = 1'b0;
`endif
    end

    // A wrap in the same cycle as a clear wins, so no event is lost.
    wrap_d = wrap_q;
    if (wr_en && (bus.address == ADDR_STATUS) && bus.writedata[0]) begin
      wrap_d = 1'b0;
    end
    if (carry_d) begin
      wrap_d = 1'b1;
    end

`ifdef ALARM_TIME_COUNTER_IRQ_EN
    irq_d = wrap_d & irq_en_d;
`else
    irq_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q   <= data_t'(RESET_COUNT);
      modulus_q <= data_t'(RESET_MODULUS);
      run_q     <= 1'b0;
      irq_en_q  <= 1'b0;
      wrap_q    <= 1'b0;
      carry_q   <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      modulus_q <= modulus_d;
      run_q     <= run_d;
      irq_en_q  <= irq_en_d;
      wrap_q    <= wrap_d;
      carry_q   <= carry_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    bus.readdata = 32'h0;
    case (bus.address)
      ADDR_COUNT:   bus.readdata = 32'(count_q);
      ADDR_MODULUS: bus.readdata = 32'(modulus_q);
      ADDR_CONTROL: bus.readdata = {30'h0, irq_en_q, run_q};
      ADDR_STATUS:  bus.readdata = {31'h0, wrap_q};
      default:      bus.readdata = 32'h0;
    endcase
  end

  assign out_port  = count_q;
  assign carry_out = carry_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_alarm_time_counter.sv
// Directed bench for alarm_time_counter: a 16-bit instance for the register map and
// counting rules, and a 4-bit instance for the full-range (MODULUS=0) wrap.
module tb_alarm_time_counter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tick_a = 1'b0;
  logic        tick_b = 1'b0;
  logic [15:0] out_a;
  logic [3:0]  out_b;
  logic        carry_a, carry_b, irq_a, irq_b;
  logic [31:0] rd;
  int          n_cmp = 0;
  int          n_err = 0;

  alarm_time_counter_if bus_a ();
  alarm_time_counter_if bus_b ();

  alarm_time_counter #(.DATA_WIDTH(16), .RESET_COUNT(0), .RESET_MODULUS(24)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a), .tick(tick_a),
    .out_port(out_a), .carry_out(carry_a), .irq(irq_a)
  );

  alarm_time_counter #(.DATA_WIDTH(4), .RESET_COUNT(0), .RESET_MODULUS(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b), .tick(tick_b),
    .out_port(out_b), .carry_out(carry_b), .irq(irq_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_a(input logic [2:0] a, input logic [31:0] d, input logic tk);
    @(negedge clk);
    bus_a.chipselect = 1'b1; bus_a.write_n = 1'b0;
    bus_a.address = a; bus_a.writedata = d; tick_a = tk;
    @(negedge clk);
    bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1; tick_a = 1'b0;
  endtask

  task automatic wr_b(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_b.chipselect = 1'b1; bus_b.write_n = 1'b0;
    bus_b.address = a; bus_b.writedata = d;
    @(negedge clk);
    bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1;
  endtask

  task automatic pulse_a();
    @(negedge clk);
    tick_a = 1'b1;
    @(negedge clk);
    tick_a = 1'b0;
  endtask

  task automatic rd_a(input logic [2:0] a, output logic [31:0] v);
    bus_a.address = a;
    #1;
    v = bus_a.readdata;
  endtask

  initial begin
    bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1; bus_a.address = 3'd0; bus_a.writedata = 32'h0;
    bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1; bus_b.address = 3'd0; bus_b.writedata = 32'h0;

    // Reset values
    #12;
    check("rst_out", 32'(out_a), 32'h0);
    check("rst_carry", 32'(carry_a), 32'h0);
    check("rst_irq", 32'(irq_a), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    rd_a(3'd0, rd); check("rst_rd_count", rd, 32'h0);
    rd_a(3'd1, rd); check("rst_rd_mod", rd, 32'h18);
    rd_a(3'd2, rd); check("rst_rd_ctrl", rd, 32'h0);
    rd_a(3'd3, rd); check("rst_rd_status", rd, 32'h0);

    // Run 22 -> 23 -> 0 with one carry pulse
    wr_a(3'd2, 32'h1, 1'b0);
    wr_a(3'd0, 32'd22, 1'b0);
    check("load22", 32'(out_a), 32'd22);
    pulse_a();
    check("tick_23", 32'(out_a), 32'd23);
    check("tick_23_carry", 32'(carry_a), 32'h0);
    pulse_a();
    check("wrap_0", 32'(out_a), 32'h0);
    check("wrap_carry", 32'(carry_a), 32'h1);
    @(negedge clk);
    check("carry_one_cycle", 32'(carry_a), 32'h0);
    rd_a(3'd3, rd); check("status_wrap", rd, 32'h1);
    wr_a(3'd3, 32'h1, 1'b0);
    rd_a(3'd3, rd); check("status_clear", rd, 32'h0);

    // COUNT write beats a same-cycle wrapping tick
    wr_a(3'd0, 32'd23, 1'b0);
    wr_a(3'd0, 32'h5, 1'b1);
    check("cnt_wr_prio", 32'(out_a), 32'h5);
    check("cnt_wr_no_carry", 32'(carry_a), 32'h0);
    rd_a(3'd3, rd); check("cnt_wr_no_wrap", rd, 32'h0);

    // RUN=0 ignores ticks; STEP plus tick is one increment
    wr_a(3'd2, 32'h0, 1'b0);
    pulse_a();
    pulse_a();
    check("run0_hold", 32'(out_a), 32'h5);
    wr_a(3'd2, 32'h1, 1'b0);
    wr_a(3'd4, 32'h0, 1'b1);
    check("step_tick_once", 32'(out_a), 32'h6);
    rd_a(3'd4, rd); check("rd_step", rd, 32'h0);

    // Out-of-range COUNT wraps on next increment
    wr_a(3'd0, 32'd30, 1'b0);
    check("load30", 32'(out_a), 32'd30);
    wr_a(3'd4, 32'h0, 1'b0);
    check("over_wrap", 32'(out_a), 32'h0);
    check("over_carry", 32'(carry_a), 32'h1);

    // MODULUS=0 full 16-bit range
    wr_a(3'd1, 32'h0, 1'b0);
    wr_a(3'd0, 32'hFFFE, 1'b0);
    wr_a(3'd4, 32'h0, 1'b0);
    check("full_ffff", 32'(out_a), 32'hFFFF);
    check("full_ffff_carry", 32'(carry_a), 32'h0);
    wr_a(3'd4, 32'h0, 1'b0);
    check("full_wrap", 32'(out_a), 32'h0);
    check("full_wrap_carry", 32'(carry_a), 32'h1);

    // MODULUS write applies only from the following cycle
    wr_a(3'd1, 32'd5, 1'b0);
    wr_a(3'd0, 32'd3, 1'b0);
    wr_a(3'd1, 32'd4, 1'b1);
    check("mod_old_used", 32'(out_a), 32'h4);
    check("mod_old_carry", 32'(carry_a), 32'h0);
    pulse_a();
    check("mod_new_wrap", 32'(out_a), 32'h0);
    check("mod_new_carry", 32'(carry_a), 32'h1);

    // Unmapped addresses
    wr_a(3'd6, 32'h55, 1'b0);
    check("unmapped_wr", 32'(out_a), 32'h0);
    rd_a(3'd5, rd); check("rd5", rd, 32'h0);
    rd_a(3'd6, rd); check("rd6", rd, 32'h0);
    rd_a(3'd7, rd); check("rd7", rd, 32'h0);
    rd_a(3'd1, rd); check("rd_mod4", rd, 32'h4);

    // Interrupt behaviour
    wr_a(3'd3, 32'h1, 1'b0);
    wr_a(3'd2, 32'h3, 1'b0);
`ifdef ALARM_TIME_COUNTER_IRQ_EN
    rd_a(3'd2, rd); check("ctrl_irq_build", rd, 32'h3);
    check("irq_idle", 32'(irq_a), 32'h0);
    wr_a(3'd0, 32'd3, 1'b0);
    pulse_a();
    check("irq_set", 32'(irq_a), 32'h1);
    wr_a(3'd3, 32'h1, 1'b0);
    check("irq_cleared", 32'(irq_a), 32'h0);
    wr_a(3'd0, 32'd3, 1'b0);
    pulse_a();
    check("irq_set2", 32'(irq_a), 32'h1);
    wr_a(3'd0, 32'd3, 1'b0);
    wr_a(3'd3, 32'h1, 1'b1);
    check("irq_clear_vs_wrap", 32'(irq_a), 32'h1);
`else
    rd_a(3'd2, rd); check("ctrl_no_irq_build", rd, 32'h1);
    wr_a(3'd0, 32'd3, 1'b0);
    pulse_a();
    check("irq_tied0", 32'(irq_a), 32'h0);
    wr_a(3'd0, 32'd3, 1'b0);
    wr_a(3'd3, 32'h1, 1'b1);
    check("irq_tied0_b", 32'(irq_a), 32'h0);
`endif
    rd_a(3'd3, rd); check("wrap_vs_clear", rd, 32'h1);
    check("wrap_vs_clear_cnt", 32'(out_a), 32'h0);
    check("wrap_vs_clear_carry", 32'(carry_a), 32'h1);

    // Reset in the middle of a wrapping increment
    wr_a(3'd0, 32'd3, 1'b0);
    @(negedge clk);
    tick_a = 1'b1;
    #2 reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_count", 32'(out_a), 32'h0);
    check("midrst_carry", 32'(carry_a), 32'h0);
    @(negedge clk);
    tick_a = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_carry", 32'(carry_a), 32'h0);
    check("post_rst_irq", 32'(irq_a), 32'h0);
    rd_a(3'd1, rd); check("post_rst_mod", rd, 32'h18);
    rd_a(3'd2, rd); check("post_rst_ctrl", rd, 32'h0);
    rd_a(3'd3, rd); check("post_rst_status", rd, 32'h0);

    // 4-bit instance: full range wrap at 0xF
    wr_b(3'd1, 32'h0);
    wr_b(3'd0, 32'hF);
    check("b_load_f", 32'(out_b), 32'hF);
    wr_b(3'd4, 32'h0);
    check("b_wrap", 32'(out_b), 32'h0);
    check("b_carry", 32'(carry_b), 32'h1);
    @(negedge clk);
    check("b_carry_drop", 32'(carry_b), 32'h0);
    check("b_irq", 32'(irq_b), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
